// File: rtl/trap_ctrl_pkg.sv
// Shared types and cause encodings for the M-mode trap sequencer.
package trap_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_TRAP  = 2'd2,
    ST_REDIR = 2'd3
  } state_t;

  localparam logic [3:0] EXC_ILLEGAL = 4'd2;
  localparam logic [3:0] EXC_EBREAK  = 4'd3;
  localparam logic [3:0] EXC_ECALL_M = 4'd11;
  localparam logic [3:0] IRQ_MSI     = 4'd3;
  localparam logic [3:0] IRQ_MTI     = 4'd7;
  localparam logic [3:0] IRQ_MEI     = 4'd11;
  localparam logic [4:0] CAUSE_MRET  = 5'h0F;

  function automatic logic [4:0] mk_cause(
    input logic       irq,
    input logic [3:0] code
  );
    return {irq, code};
  endfunction

endpackage

// File: rtl/trap_ctrl_prio.sv
// Fixed-priority selection of the trap event for the committing instruction.
// Interrupts always win over a synchronous exception on the same commit.
module trap_prio
  import trap_ctrl_pkg::*;
(
  input  logic       i_valid,
  input  logic       i_illegal,
  input  logic       i_ebreak,
  input  logic       i_ecall,
  input  logic       i_mret,
  input  logic [2:0] i_mip,
  input  logic       i_mie,
  input  logic [2:0] i_mie_bits,
  output logic       o_take,
  output logic [4:0] o_cause
);

  logic [2:0] w_irq;

  // bit 2 = external, bit 1 = software, bit 0 = timer
  assign w_irq = i_mip & i_mie_bits & {3{i_mie}};

  always_comb begin
    o_take  = i_valid;
    o_cause = '0;
    if (!i_valid)
      o_take = 1'b0;
    else if (w_irq[2])
      o_cause = mk_cause(1'b1, IRQ_MEI);
    else if (w_irq[1])
      o_cause = mk_cause(1'b1, IRQ_MSI);
    else if (w_irq[0])
      o_cause = mk_cause(1'b1, IRQ_MTI);
    else if (i_illegal)
      o_cause = mk_cause(1'b0, EXC_ILLEGAL);
    else if (i_ebreak)
      o_cause = mk_cause(1'b0, EXC_EBREAK);
    else if (i_ecall)
      o_cause = mk_cause(1'b0, EXC_ECALL_M);
    else if (i_mret)
      o_cause = CAUSE_MRET;
    else
      o_take = 1'b0;
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: commit-stage event -> LSU drain -> CSR trap pulse -> redirect.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int DRAIN_MAX = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_pc,
  input  logic            exc_illegal,
  input  logic            exc_ebreak,
  input  logic            exc_ecall,
  input  logic            is_mret,
  input  logic            mip_meip,
  input  logic            mip_msip,
  input  logic            mip_mtip,
  input  logic            mstatus_mie,
  input  logic [2:0]      mie_bits,
  input  logic            lsu_busy,
  input  logic [XLEN-1:0] trap_target_pc,
  output logic            commit_kill,
  output logic            stall_req,
  output logic            exception_flag,
  output logic [4:0]      exception_cause,
  output logic [XLEN-1:0] epc,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            drain_timeout
);

  localparam int CW = $clog2(DRAIN_MAX + 1);
  localparam logic [CW-1:0] MAXC = CW'(DRAIN_MAX);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_inc;
  logic [4:0]      r_cause;
  logic [XLEN-1:0] r_epc;
  logic            r_timeout;
  logic            w_take;
  logic [4:0]      w_cause;
  logic            w_idle;

  trap_prio u_prio (
    .i_valid    (commit_valid),
    .i_illegal  (exc_illegal),
    .i_ebreak   (exc_ebreak),
    .i_ecall    (exc_ecall),
    .i_mret     (is_mret),
    .i_mip      ({mip_meip, mip_msip, mip_mtip}),
    .i_mie      (mstatus_mie),
    .i_mie_bits (mie_bits),
    .o_take     (w_take),
    .o_cause    (w_cause)
  );

  assign w_idle      = (r_state == ST_IDLE);
  assign commit_kill = w_idle & w_take;
  assign w_cnt_inc   = r_cnt + 1'b1;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:
        if (w_take)
          w_next = lsu_busy ? ST_DRAIN : ST_TRAP;
      ST_DRAIN:
        if (!lsu_busy)
          w_next = ST_TRAP;
      ST_TRAP:  w_next = ST_REDIR;
      ST_REDIR: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  assign stall_req       = (r_state == ST_DRAIN) |
                           (r_state == ST_TRAP);
  assign exception_flag  = (r_state == ST_TRAP);
  assign exception_cause = exception_flag ? r_cause : '0;
  assign epc             = exception_flag ? r_epc : '0;
  assign redirect_valid  = (r_state == ST_REDIR);
  assign redirect_pc     = redirect_valid ? trap_target_pc : '0;
  assign drain_timeout   = r_timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_cause   <= '0;
      r_epc     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (commit_kill) begin
        r_cause <= w_cause;
        // mret has no faulting pc to record
        r_epc   <= (w_cause == CAUSE_MRET) ? '0 : commit_pc;
      end
      if (r_state == ST_DRAIN) begin
        if (r_cnt != MAXC) begin
          r_cnt <= w_cnt_inc;
          if (w_cnt_inc == MAXC)
            r_timeout <= 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  a_commit_idle: assert property (
    @(posedge clk) disable iff (!rst)
    commit_valid |-> (r_state == ST_IDLE)
  );

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: one task per scenario, inline checks.
module tb_trap_ctrl;

  logic        clk;
  logic        rst;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic        exc_illegal;
  logic        exc_ebreak;
  logic        exc_ecall;
  logic        is_mret;
  logic        mip_meip;
  logic        mip_msip;
  logic        mip_mtip;
  logic        mstatus_mie;
  logic [2:0]  mie_bits;
  logic        lsu_busy;
  logic [63:0] trap_target_pc;

  logic        commit_kill;
  logic        stall_req;
  logic        exception_flag;
  logic [4:0]  exception_cause;
  logic [63:0] epc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        drain_timeout;

  logic        d4_kill;
  logic        d4_stall;
  logic        d4_flag;
  logic [4:0]  d4_cause;
  logic [63:0] d4_epc;
  logic        d4_rv;
  logic [63:0] d4_rpc;
  logic        d4_to;

  int n_cmp;
  int n_bad;

  trap_ctrl u_dut (
    .clk             (clk),
    .rst             (rst),
    .commit_valid    (commit_valid),
    .commit_pc       (commit_pc),
    .exc_illegal     (exc_illegal),
    .exc_ebreak      (exc_ebreak),
    .exc_ecall       (exc_ecall),
    .is_mret         (is_mret),
    .mip_meip        (mip_meip),
    .mip_msip        (mip_msip),
    .mip_mtip        (mip_mtip),
    .mstatus_mie     (mstatus_mie),
    .mie_bits        (mie_bits),
    .lsu_busy        (lsu_busy),
    .trap_target_pc  (trap_target_pc),
    .commit_kill     (commit_kill),
    .stall_req       (stall_req),
    .exception_flag  (exception_flag),
    .exception_cause (exception_cause),
    .epc             (epc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .drain_timeout   (drain_timeout)
  );

  trap_ctrl #(.XLEN(64), .DRAIN_MAX(4)) u_d4 (
    .clk             (clk),
    .rst             (rst),
    .commit_valid    (commit_valid),
    .commit_pc       (commit_pc),
    .exc_illegal     (exc_illegal),
    .exc_ebreak      (exc_ebreak),
    .exc_ecall       (exc_ecall),
    .is_mret         (is_mret),
    .mip_meip        (mip_meip),
    .mip_msip        (mip_msip),
    .mip_mtip        (mip_mtip),
    .mstatus_mie     (mstatus_mie),
    .mie_bits        (mie_bits),
    .lsu_busy        (lsu_busy),
    .trap_target_pc  (trap_target_pc),
    .commit_kill     (d4_kill),
    .stall_req       (d4_stall),
    .exception_flag  (d4_flag),
    .exception_cause (d4_cause),
    .epc             (d4_epc),
    .redirect_valid  (d4_rv),
    .redirect_pc     (d4_rpc),
    .drain_timeout   (d4_to)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_commit();
    commit_valid = 1'b0;
    commit_pc    = '0;
    exc_illegal  = 1'b0;
    exc_ebreak   = 1'b0;
    exc_ecall    = 1'b0;
    is_mret      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clr_commit();
    mip_meip = 0; mip_msip = 0; mip_mtip = 0;
    mstatus_mie = 0; mie_bits = '0;
    lsu_busy = 0; trap_target_pc = 64'h8000_0100;
    #2;
    n_cmp++;
    if ({commit_kill, stall_req, exception_flag,
         redirect_valid, drain_timeout} !== 5'b0) begin
      n_bad++;
      $display("FAIL rst_ctl: got %b want 00000",
        {commit_kill, stall_req, exception_flag,
         redirect_valid, drain_timeout});
    end
    n_cmp++;
    if ({exception_cause, epc, redirect_pc} !== '0) begin
      n_bad++;
      $display("FAIL rst_data: got %h %h %h want 0",
        exception_cause, epc, redirect_pc);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_ecall();
    commit_valid = 1; exc_ecall = 1;
    commit_pc = 64'h8000_0010;
    #1;
    n_cmp++;
    if (commit_kill !== 1'b1 || stall_req !== 1'b0) begin
      n_bad++;
      $display("FAIL ecall_kill: got kill=%b stall=%b want 1 0",
        commit_kill, stall_req);
    end
    tick();
    clr_commit();
    n_cmp++;
    if (exception_flag !== 1'b1 || stall_req !== 1'b1) begin
      n_bad++;
      $display("FAIL ecall_flag: got flag=%b stall=%b want 1 1",
        exception_flag, stall_req);
    end
    n_cmp++;
    if (exception_cause !== 5'h0B || epc !== 64'h8000_0010) begin
      n_bad++;
      $display("FAIL ecall_cause: got %h/%h want 0b/80000010",
        exception_cause, epc);
    end
    tick();
    n_cmp++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0100
        || exception_flag !== 1'b0 || stall_req !== 1'b0) begin
      n_bad++;
      $display("FAIL ecall_redir: got rv=%b pc=%h fl=%b st=%b want 1 80000100 0 0",
        redirect_valid, redirect_pc, exception_flag, stall_req);
    end
    tick();
    n_cmp++;
    if (redirect_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ecall_idle: got rv=%b want 0", redirect_valid);
    end
  endtask

  task automatic test_irq_mask();
    mip_mtip = 1; mie_bits = 3'b001; mstatus_mie = 0;
    commit_valid = 1; commit_pc = 64'h1000;
    #1;
    n_cmp++;
    if (commit_kill !== 1'b0) begin
      n_bad++;
      $display("FAIL irq_masked: got kill=%b want 0", commit_kill);
    end
    tick();
    clr_commit();
    mstatus_mie = 1;
    #1;
    n_cmp++;
    if (commit_kill !== 1'b0 || exception_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL irq_nocommit: got kill=%b fl=%b want 0 0",
        commit_kill, exception_flag);
    end
    tick();
    commit_valid = 1; commit_pc = 64'h2000;
    #1;
    n_cmp++;
    if (commit_kill !== 1'b1) begin
      n_bad++;
      $display("FAIL irq_kill: got kill=%b want 1", commit_kill);
    end
    tick();
    clr_commit();
    n_cmp++;
    if (exception_cause !== 5'h17 || epc !== 64'h2000) begin
      n_bad++;
      $display("FAIL irq_mti: got %h/%h want 17/2000",
        exception_cause, epc);
    end
    mip_mtip = 0;
    tick(); tick();
  endtask

  task automatic test_irq_vs_exc();
    mip_meip = 1; mie_bits = 3'b100; mstatus_mie = 1;
    commit_valid = 1; exc_ecall = 1; commit_pc = 64'h3000;
    tick();
    clr_commit();
    mip_meip = 0;
    n_cmp++;
    if (exception_flag !== 1'b1 || exception_cause !== 5'h1B) begin
      n_bad++;
      $display("FAIL irq_beats_exc: got fl=%b cause=%h want 1 1b",
        exception_flag, exception_cause);
    end
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    trap_target_pc = 64'h5555_0000;
    commit_valid = 1; is_mret = 1; commit_pc = 64'h4000;
    tick();
    clr_commit();
    n_cmp++;
    if (exception_cause !== 5'h0F || epc !== 64'h0) begin
      n_bad++;
      $display("FAIL mret_cause: got %h/%h want 0f/0",
        exception_cause, epc);
    end
    tick();
    n_cmp++;
    if (redirect_pc !== 64'h5555_0000) begin
      n_bad++;
      $display("FAIL mret_redir: got %h want 55550000", redirect_pc);
    end
    tick();
    commit_valid = 1; exc_ebreak = 1; commit_pc = 64'h4100;
    tick();
    clr_commit();
    n_cmp++;
    if (exception_cause !== 5'h03 || epc !== 64'h4100) begin
      n_bad++;
      $display("FAIL b2b_ebreak: got %h/%h want 03/4100",
        exception_cause, epc);
    end
    tick(); tick();
  endtask

  task automatic test_drain();
    commit_valid = 1; exc_illegal = 1;
    commit_pc = 64'h6000; lsu_busy = 1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      clr_commit();
      if (i == 5) lsu_busy = 0;
      n_cmp++;
      if (exception_flag !== 1'b0 || stall_req !== 1'b1) begin
        n_bad++;
        $display("FAIL drain_wait%0d: got fl=%b st=%b want 0 1",
          i, exception_flag, stall_req);
      end
    end
    tick();
    n_cmp++;
    if (exception_flag !== 1'b1 || exception_cause !== 5'h02
        || epc !== 64'h6000 || stall_req !== 1'b1) begin
      n_bad++;
      $display("FAIL drain_flag: got fl=%b c=%h e=%h st=%b want 1 02 6000 1",
        exception_flag, exception_cause, epc, stall_req);
    end
    tick();
    n_cmp++;
    if (redirect_valid !== 1'b1 || stall_req !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_redir: got rv=%b st=%b want 1 0",
        redirect_valid, stall_req);
    end
    tick();
  endtask

  task automatic test_timeout();
    rst = 0;
    #1;
    n_cmp++;
    if (d4_to !== 1'b0) begin
      n_bad++;
      $display("FAIL to_clear: got %b want 0", d4_to);
    end
    tick();
    rst = 1;
    tick();
    commit_valid = 1; exc_ecall = 1;
    commit_pc = 64'h7000; lsu_busy = 1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      clr_commit();
      if (k == 10) lsu_busy = 0;
      n_cmp++;
      if (d4_to !== (k >= 5) || d4_flag !== 1'b0) begin
        n_bad++;
        $display("FAIL to_cyc%0d: got to=%b fl=%b want %b 0",
          k, d4_to, d4_flag, (k >= 5));
      end
    end
    tick();
    n_cmp++;
    if (d4_flag !== 1'b1 || d4_cause !== 5'h0B || d4_to !== 1'b1) begin
      n_bad++;
      $display("FAIL to_trap: got fl=%b c=%h to=%b want 1 0b 1",
        d4_flag, d4_cause, d4_to);
    end
    n_cmp++;
    if (drain_timeout !== 1'b0 || exception_flag !== 1'b1) begin
      n_bad++;
      $display("FAIL to_big: got to=%b fl=%b want 0 1",
        drain_timeout, exception_flag);
    end
    tick();
    n_cmp++;
    if (d4_rv !== 1'b1 || d4_rpc !== trap_target_pc) begin
      n_bad++;
      $display("FAIL to_redir: got rv=%b pc=%h want 1 %h",
        d4_rv, d4_rpc, trap_target_pc);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    commit_valid = 1; exc_illegal = 1;
    commit_pc = 64'h9000; lsu_busy = 1;
    tick();
    clr_commit();
    tick();
    n_cmp++;
    if (stall_req !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_drain: got st=%b want 1", stall_req);
    end
    #2;
    rst = 0;
    lsu_busy = 0;
    #1;
    n_cmp++;
    if ({stall_req, exception_flag, redirect_valid,
         d4_stall, d4_to} !== 5'b0) begin
      n_bad++;
      $display("FAIL mid_rst: got %b want 00000",
        {stall_req, exception_flag, redirect_valid,
         d4_stall, d4_to});
    end
    tick();
    rst = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if (exception_flag !== 1'b0 || redirect_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_post%0d: got fl=%b rv=%b want 0 0",
          k, exception_flag, redirect_valid);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_ecall();
    test_irq_mask();
    test_irq_vs_exc();
    test_back_to_back();
    test_drain();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
